add_core_pipe: RTL and testbench

- Registered adder stage with a small output buffer, placed between the add bench's input agent and output agent.
- Consumes operand pairs over a valid/ready handshake from the agent_in side.
- Produces sum/carry results over a valid/ready handshake to the agent_out side.
- Absorbs downstream backpressure in a DEPTH-entry result FIFO and keeps a wrapping completed-transaction counter.

---
 rtl/add_core_pipe_pkg.sv | 20 ++
 rtl/add_core_fifo.sv | 83 ++++++++
 rtl/add_core_pipe.sv | 117 +++++++++++
 tb/tb_add_core_pipe.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/add_core_pipe_pkg.sv
// Shared constants and result layout for the registered adder pipe.
// Combinational-only content; no latency or flow-control behaviour lives here.
// Consumers size their own result struct from DATA_W via res_w().
package add_core_pipe_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int DEPTH_DEF  = 2;
  localparam int CNT_W_DEF  = 16;

  // Reference layout at the default width; wider instances rebuild it from DATA_W.
  typedef struct packed {
    logic                  carry;
    logic [DATA_W_DEF-1:0] sum;
  } add_res_t;

  function automatic int res_w(input int data_w);
    return data_w + 1;
  endfunction

endpackage

// File: rtl/add_core_fifo.sv
// Generic DEPTH-entry synchronous FIFO with occupancy output and explicit pointer wrap.
// Latency: a push is visible at rd_dat the cycle after the push edge when empty.
// Backpressure: push is ignored when full, pop is ignored when empty.
module add_core_fifo
  import add_core_pipe_pkg::*;
#(
  parameter int  WIDTH = res_w(DATA_W_DEF),
  parameter int  DEPTH = DEPTH_DEF,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int LVL_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_dat,
  output logic [LVL_W-1:0] level,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             do_push, do_pop;

  // Compare against DEPTH-1 rather than relying on natural overflow so
  // non-power-of-two depths wrap correctly.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (level_q == LVL_W'(DEPTH));
  assign empty   = (level_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_dat  = mem_q[rd_ptr_q];
  assign level   = level_q;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wr_dat;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (do_pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
    level_q <= LVL_W'(DEPTH));
  a_ptr_range : assert property (@(posedge clk) disable iff (!rst_n)
    (wr_ptr_q < PTR_W'(DEPTH)) && (rd_ptr_q < PTR_W'(DEPTH)));

endmodule

// File: rtl/add_core_pipe.sv
// Registered adder feeding a DEPTH-entry result FIFO, with wrapping pop counter; ADD_CORE_PIPE_SAT_EN adds saturation and sat_seen.
// Latency: operands pushed at edge N appear on out_* right after edge N when the FIFO was empty.
// Backpressure: in_ready = FIFO not full, from registered state only; no out_ready -> in_ready path.
module add_core_pipe
  import add_core_pipe_pkg::*;
#(
  parameter int  DATA_W = DATA_W_DEF,
  parameter int  DEPTH  = DEPTH_DEF,
  parameter int  CNT_W  = CNT_W_DEF,
  localparam int LVL_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_sum,
  output logic              out_carry,
  output logic [CNT_W-1:0]  txn_count,
`ifdef ADD_CORE_PIPE_SAT_EN
  output logic              sat_seen,
`endif
  output logic [LVL_W-1:0]  fifo_level
);

  typedef struct packed {
    logic              carry;
    logic [DATA_W-1:0] sum;
  } res_t;

  logic [DATA_W:0]  raw_sum;
  res_t             push_res;
  res_t             head_res;
  res_t             hold_q, hold_d;
  logic [CNT_W-1:0] txn_cnt_q, txn_cnt_d;
  logic             push, pop;
  logic             fifo_full, fifo_empty;

  assign raw_sum   = {1'b0, in_a} + {1'b0, in_b};
  assign in_ready  = !fifo_full;
  assign out_valid = !fifo_empty;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    push_res.carry = raw_sum[DATA_W];
    push_res.sum   = raw_sum[DATA_W-1:0];
`ifdef ADD_CORE_PIPE_SAT_EN
    if (raw_sum[DATA_W]) begin
      push_res.sum = '1;
    end
`endif
  end

  add_core_fifo #(
    .WIDTH ($bits(res_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .push   (push),
    .wr_dat (push_res),
    .pop    (pop),
    .rd_dat (head_res),
    .level  (fifo_level),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  // The FIFO head slot moves on after the last pop, so the last delivered
  // result is kept aside to hold out_* steady while empty.
  always_comb begin
    hold_d    = pop ? head_res : hold_q;
    txn_cnt_d = pop ? txn_cnt_q + 1'b1 : txn_cnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q    <= '0;
      txn_cnt_q <= '0;
    end else begin
      hold_q    <= hold_d;
      txn_cnt_q <= txn_cnt_d;
    end
  end

  assign out_sum   = out_valid ? head_res.sum : hold_q.sum;
  assign out_carry = out_valid ? head_res.carry : hold_q.carry;
  assign txn_count = txn_cnt_q;

`ifdef ADD_CORE_PIPE_SAT_EN
  logic sat_seen_q, sat_seen_d;

  always_comb begin
    sat_seen_d = sat_seen_q | (push & push_res.carry);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_seen_q <= 1'b0;
    end else begin
      sat_seen_q <= sat_seen_d;
    end
  end

  assign sat_seen = sat_seen_q;
`endif

  a_no_push_full : assert property (@(posedge clk) disable iff (!rst_n)
    !(push && fifo_full));
  a_head_stable : assert property (@(posedge clk) disable iff (!rst_n)
    (out_valid && !out_ready) |=> ($stable(out_sum) && $stable(out_carry)));

endmodule

// File: tb/tb_add_core_pipe.sv
// Randomized scoreboard bench for add_core_pipe at DEPTH=3 (non-power-of-two wrap) and CNT_W=4 (counter wrap).
module tb_add_core_pipe;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 3;
  localparam int CNT_W  = 4;
  localparam int LVL_W  = $clog2(DEPTH + 1);

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_a, in_b;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_sum;
  logic              out_carry;
  logic [CNT_W-1:0]  txn_count;
  logic [LVL_W-1:0]  fifo_level;
`ifdef ADD_CORE_PIPE_SAT_EN
  logic              sat_seen;
`endif

  logic drv_rdy, rnd_rdy, rnd_en;
  assign out_ready = rnd_en ? rnd_rdy : drv_rdy;

  int n_cmp = 0;
  int n_err = 0;

  logic [DATA_W:0] exp_q[$];
  logic [DATA_W:0] m_last;
  int              m_cnt;
  logic            m_sat;

  add_core_pipe #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_sum    (out_sum),
    .out_carry  (out_carry),
    .txn_count  (txn_count),
`ifdef ADD_CORE_PIPE_SAT_EN
    .sat_seen   (sat_seen),
`endif
    .fifo_level (fifo_level)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer addition, carry = sum exceeds the DATA_W range.
  function automatic logic [DATA_W:0] model_res(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    int   s;
    logic c;
    s = int'(a) + int'(b);
    c = (s >= (1 << DATA_W));
    s = s % (1 << DATA_W);
`ifdef ADD_CORE_PIPE_SAT_EN
    if (c) s = (1 << DATA_W) - 1;
`endif
    return {c, DATA_W'(s)};
  endfunction

  // Monitor: inputs settle 1 time unit after posedge, so the negedge sees
  // exactly what the next posedge will act on.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_q.delete();
        m_last = '0;
        m_cnt  = 0;
        m_sat  = 1'b0;
      end else begin
        int sz;
        sz = exp_q.size();
        check("fifo_level", 32'(fifo_level), sz);
        check("in_ready", 32'(in_ready), 32'(sz < DEPTH));
        check("out_valid", 32'(out_valid), 32'(sz != 0));
        check("txn_count", 32'(txn_count), m_cnt);
`ifdef ADD_CORE_PIPE_SAT_EN
        check("sat_seen", 32'(sat_seen), 32'(m_sat));
`endif
        if (sz != 0) begin
          check("head_result", 32'({out_carry, out_sum}), 32'(exp_q[0]));
          if (out_ready) begin
            m_last = exp_q.pop_front();
            m_cnt  = (m_cnt + 1) % (1 << CNT_W);
          end
        end else begin
          check("held_result", 32'({out_carry, out_sum}), 32'(m_last));
        end
        if (in_valid && sz < DEPTH) begin
          exp_q.push_back(model_res(in_a, in_b));
          m_sat = m_sat | model_res(in_a, in_b)[DATA_W];
        end
      end
    end
  end

  initial begin
    rnd_rdy = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      rnd_rdy = 1'($urandom_range(0, 1));
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    int waited = 0;
    bit acc    = 1'b0;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    while (!acc && waited < 200) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      waited++;
    end
    if (!acc) begin
      n_cmp++;
      n_err++;
      $display("FAIL send_timeout: in_ready never 1 for a=%0h b=%0h", a, b);
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int k = 0;
    while (k < 200) begin
      @(negedge clk);
      if (!out_valid) break;
      k++;
    end
    if (k >= 200) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain_timeout: out_valid stuck at 1, level=%0d", fifo_level);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_a     = '0;
    in_b     = '0;
    drv_rdy  = 1'b0;
    rnd_en   = 1'b0;
    #2;
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_sum", 32'({out_carry, out_sum}), 0);
    check("rst_txn_count", 32'(txn_count), 0);
    check("rst_fifo_level", 32'(fifo_level), 0);
    idle(2);
    rst_n = 1'b1;
    @(negedge clk);
    check("in_ready_after_rst", 32'(in_ready), 1);
    idle(1);

    // Single transaction
    drv_rdy = 1'b1;
    send(8'h05, 8'h03);
    check("single_valid", 32'(out_valid), 1);
    check("single_result", 32'({out_carry, out_sum}), 32'(9'h008));
    idle(1);
    check("single_txn_count", 32'(txn_count), 1);

    // Carry-out
    send(8'hFF, 8'h02);
`ifdef ADD_CORE_PIPE_SAT_EN
    check("carry_result", 32'({out_carry, out_sum}), 32'(9'h1FF));
`else
    check("carry_result", 32'({out_carry, out_sum}), 32'(9'h101));
`endif
    idle(2);

    // Backpressure up to full; extra operand held until a slot frees
    drv_rdy = 1'b0;
    for (int i = 1; i <= DEPTH; i++) send(DATA_W'(i), DATA_W'(i));
    check("full_level", 32'(fifo_level), DEPTH);
    check("full_in_ready", 32'(in_ready), 0);
    in_valid = 1'b1;
    in_a     = 8'h09;
    in_b     = 8'h09;
    idle(4);
    check("held_in_ready", 32'(in_ready), 0);
    check("held_level", 32'(fifo_level), DEPTH);
    drv_rdy = 1'b1;
    send(8'h09, 8'h09);
    drain();

    // Streaming: push and pop every cycle at level 1
    for (int i = 0; i < 20; i++) begin
      send(DATA_W'($urandom), DATA_W'($urandom));
      check("stream_level", 32'(fifo_level), 1);
    end
    drain();

    // Random traffic with random backpressure
    rnd_en = 1'b1;
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 3) == 0) idle(1);
      send(DATA_W'($urandom), DATA_W'($urandom));
    end
    rnd_en = 1'b0;
    drain();

    // Counter wrap: 17 pops on a 4-bit counter
    pulse_reset();
    for (int i = 0; i < 17; i++) send(DATA_W'(i * 7), DATA_W'(i));
    drain();
    check("cnt_wrap", 32'(txn_count), 1);

    // Reset with results pending
    drv_rdy = 1'b0;
    send(8'h11, 8'h22);
    send(8'h33, 8'h44);
    check("pre_rst_level", 32'(fifo_level), 2);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 0);
    check("mid_rst_txn_count", 32'(txn_count), 0);
    check("mid_rst_level", 32'(fifo_level), 0);
    idle(2);
    rst_n   = 1'b1;
    drv_rdy = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", 32'(in_ready), 1);
    idle(5);
    check("post_rst_no_stale", 32'(out_valid), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
